// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if: bundles the fetch, data and memory handshakes of the port arbiter.
// The slave view belongs to the arbiter. The master view is the surrounding
// pipeline and memory, which drive requests and memory responses.
interface mem_port_arbiter_if;
  // Fetch side
  logic        if_req;
  logic [31:0] if_addr;
  logic [31:0] if_rdata;
  logic        if_valid;
  // Data side
  logic        d_req;
  logic        d_we;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [3:0]  d_wstrb;
  logic [31:0] d_rdata;
  logic        d_valid;
  // Memory side
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_ready;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;

  modport slave (
    input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, d_wstrb,
    input  mem_ready, mem_rvalid, mem_rdata,
    output if_rdata, if_valid, d_rdata, d_valid,
    output mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb
  );

  modport master (
    output if_req, if_addr, d_req, d_we, d_addr, d_wdata, d_wstrb,
    output mem_ready, mem_rvalid, mem_rdata,
    input  if_rdata, if_valid, d_rdata, d_valid,
    input  mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares the core's single memory port between instruction fetch and
// data access. One transaction in flight, data wins over fetch, all outputs registered.
// Optional fetch starvation guard: define ARB_FETCH_GUARD_EN to compile it in.
module mem_port_arbiter #(
  parameter int unsigned MAX_DATA_RUN = 4
) (
  input logic               clk,
  input logic               rst_n,
  mem_port_arbiter_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StReq, StWait, StResp} state_e;

  state_e      state_q, state_d;
  logic        load_en;
  logic        rsp_en;
  logic        grant_data;
  logic        force_fetch;
  logic        gnt_data_q;
  logic        we_q;
  logic        mem_req_q;
  logic        if_valid_q;
  logic        d_valid_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [3:0]  wstrb_q;
  logic [31:0] if_rdata_q;
  logic [31:0] d_rdata_q;

  // The run counter is 4 bits wide, so larger limits could never be reached
  if ((MAX_DATA_RUN < 1) || (MAX_DATA_RUN > 15)) begin : g_bad_max_data_run
    $error("MAX_DATA_RUN must be in 1..15");
  end

`ifdef ARB_FETCH_GUARD_EN
  localparam logic [3:0] MaxRun = 4'(MAX_DATA_RUN);

  logic [3:0] run_q;

  assign force_fetch = bus.if_req && (run_q == MaxRun);

  // Count data grants that overtook a waiting fetch; any other grant restarts the run
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_q <= '0;
    end else if (load_en) begin
      run_q <= (grant_data && bus.if_req) ? run_q + 4'd1 : 4'd0;
    end
  end
`else
  assign force_fetch = 1'b0;
`endif

  // Next-state logic and grant decision; requests are looked at only in idle
  always_comb begin
    state_d    = state_q;
    load_en    = 1'b0;
    grant_data = 1'b0;
    rsp_en     = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (bus.d_req || bus.if_req) begin
          state_d    = StReq;
          load_en    = 1'b1;
          grant_data = bus.d_req && !force_fetch;
        end
      end
      StReq: begin
        if (bus.mem_ready) begin
          state_d = StWait;
        end
      end
      StWait: begin
        if (bus.mem_rvalid) begin
          state_d = StResp;
          rsp_en  = 1'b1;
        end
      end
      StResp: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Capture the granted request; reads never carry byte enables
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gnt_data_q <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      wstrb_q    <= '0;
    end else if (load_en) begin
      gnt_data_q <= grant_data;
      we_q       <= grant_data && bus.d_we;
      addr_q     <= (grant_data ? bus.d_addr : bus.if_addr) & 32'hFFFF_FFFC;
      wdata_q    <= grant_data ? bus.d_wdata : 32'h0;
      wstrb_q    <= (grant_data && bus.d_we) ? bus.d_wstrb : 4'h0;
    end
  end

  // Registered handshake outputs, computed from the upcoming state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_req_q  <= 1'b0;
      if_valid_q <= 1'b0;
      d_valid_q  <= 1'b0;
    end else begin
      mem_req_q  <= (state_d == StReq);
      if_valid_q <= rsp_en && !gnt_data_q;
      d_valid_q  <= rsp_en && gnt_data_q;
    end
  end

  // Read data per side, held until that side's next response
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      if_rdata_q <= '0;
      d_rdata_q  <= '0;
    end else if (rsp_en) begin
      if (gnt_data_q) begin
        d_rdata_q <= bus.mem_rdata;
      end else begin
        if_rdata_q <= bus.mem_rdata;
      end
    end
  end

  assign bus.mem_req   = mem_req_q;
  assign bus.mem_we    = we_q;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;
  assign bus.mem_wstrb = wstrb_q;
  assign bus.if_valid  = if_valid_q;
  assign bus.if_rdata  = if_rdata_q;
  assign bus.d_valid   = d_valid_q;
  assign bus.d_rdata   = d_rdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed scenarios followed by random traffic, every cycle compared
// against a transaction-level model of the arbiter.
module tb_mem_port_arbiter;

  localparam int unsigned MaxRun = 2;
`ifdef ARB_FETCH_GUARD_EN
  localparam bit Guard = 1'b1;
`else
  localparam bit Guard = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mem_port_arbiter_if bus ();

  mem_port_arbiter #(.MAX_DATA_RUN(MaxRun)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  // Model: life of the single outstanding transaction
  bit          m_free, m_issue, m_wait, m_resp, m_side_d, m_we;
  logic [31:0] m_addr, m_wdata, m_if_rdata, m_d_rdata;
  logic [3:0]  m_wstrb;
  int          m_run;

  // Inputs as sampled at the coming edge
  logic        s_rst, s_ir, s_dr, s_dwe, s_rdy, s_rv;
  logic [31:0] s_ia, s_da, s_dwd, s_rd;
  logic [3:0]  s_dws;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_free = 1'b1; m_issue = 1'b0; m_wait = 1'b0; m_resp = 1'b0;
    m_side_d = 1'b0; m_we = 1'b0; m_addr = '0; m_wdata = '0; m_wstrb = '0;
    m_if_rdata = '0; m_d_rdata = '0; m_run = 0;
  endtask

  task automatic model_step();
    bit take_d;
    if (m_resp) begin
      m_resp = 1'b0;
      m_free = 1'b1;
    end else if (m_free) begin
      if (s_dr || s_ir) begin
        take_d = s_dr && !(Guard && s_ir && (m_run == int'(MaxRun)));
        m_side_d = take_d;
        if (take_d) begin
          m_addr  = {s_da[31:2], 2'b00};
          m_we    = s_dwe;
          m_wdata = s_dwd;
          m_wstrb = s_dwe ? s_dws : 4'h0;
          m_run   = s_ir ? m_run + 1 : 0;
        end else begin
          m_addr  = {s_ia[31:2], 2'b00};
          m_we    = 1'b0;
          m_wstrb = 4'h0;
          m_run   = 0;
        end
        m_free  = 1'b0;
        m_issue = 1'b1;
      end
    end else if (m_issue) begin
      if (s_rdy) begin
        m_issue = 1'b0;
        m_wait  = 1'b1;
      end
    end else if (m_wait) begin
      if (s_rv) begin
        m_wait = 1'b0;
        m_resp = 1'b1;
        if (m_side_d) m_d_rdata = s_rd;
        else          m_if_rdata = s_rd;
      end
    end
  endtask

  task automatic check_outputs();
    chk("mem_req", bus.mem_req, m_issue);
    chk("if_valid", bus.if_valid, m_resp && !m_side_d);
    chk("d_valid", bus.d_valid, m_resp && m_side_d);
    chk("if_rdata", bus.if_rdata, m_if_rdata);
    chk("d_rdata", bus.d_rdata, m_d_rdata);
    if (m_issue) begin
      chk("mem_addr", bus.mem_addr, m_addr);
      chk("mem_we", bus.mem_we, m_we);
      chk("mem_wstrb", bus.mem_wstrb, m_wstrb);
      if (m_we) chk("mem_wdata", bus.mem_wdata, m_wdata);
    end
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_mem_req"}, bus.mem_req, 0);
    chk({tag, "_mem_we"}, bus.mem_we, 0);
    chk({tag, "_mem_addr"}, bus.mem_addr, 0);
    chk({tag, "_mem_wdata"}, bus.mem_wdata, 0);
    chk({tag, "_mem_wstrb"}, bus.mem_wstrb, 0);
    chk({tag, "_if_valid"}, bus.if_valid, 0);
    chk({tag, "_d_valid"}, bus.d_valid, 0);
    chk({tag, "_if_rdata"}, bus.if_rdata, 0);
    chk({tag, "_d_rdata"}, bus.d_rdata, 0);
  endtask

  // One clock: sample inputs, advance, update the model, compare
  task automatic cycle();
    s_rst = rst_n; s_ir = bus.if_req; s_ia = bus.if_addr; s_dr = bus.d_req;
    s_dwe = bus.d_we; s_da = bus.d_addr; s_dwd = bus.d_wdata; s_dws = bus.d_wstrb;
    s_rdy = bus.mem_ready; s_rv = bus.mem_rvalid; s_rd = bus.mem_rdata;
    @(posedge clk);
    #1;
    if (!s_rst || !rst_n) model_reset();
    else model_step();
    check_outputs();
  endtask

  // Serve the single outstanding request with a zero-stall memory
  task automatic drain(input logic [31:0] rd);
    bit done = 1'b0;
    for (int c = 0; c < 12 && !done; c++) begin
      if (bus.if_valid || bus.d_valid) begin
        done = 1'b1;
        bus.if_req = 1'b0;
        bus.d_req  = 1'b0;
      end
      bus.mem_ready  = 1'b1;
      bus.mem_rvalid = m_wait;
      bus.mem_rdata  = rd;
      cycle();
    end
    chk("drain_done", done, 1);
    bus.mem_ready  = 1'b0;
    bus.mem_rvalid = 1'b0;
  endtask

  initial begin
    int dv_cnt, dv_at, iv_cnt, mr_cnt, ngr;
    int gr[6];
    bit prev, done;

    bus.if_req = 0; bus.if_addr = '0; bus.d_req = 0; bus.d_we = 0; bus.d_addr = '0;
    bus.d_wdata = '0; bus.d_wstrb = '0; bus.mem_ready = 0; bus.mem_rvalid = 0;
    bus.mem_rdata = '0;
    model_reset();

    // Reset state
    repeat (2) cycle();
    check_all_zero("reset");
    rst_n = 1'b1;
    cycle();

    // Single fetch, minimum latency
    bus.if_req = 1; bus.if_addr = 32'h0000_1003;
    cycle();
    chk("fetch_mem_req", bus.mem_req, 1);
    chk("fetch_mem_addr", bus.mem_addr, 32'h0000_1000);
    chk("fetch_mem_wstrb", bus.mem_wstrb, 0);
    chk("fetch_mem_we", bus.mem_we, 0);
    bus.mem_ready = 1;
    cycle();
    bus.mem_ready = 0; bus.mem_rvalid = 1; bus.mem_rdata = 32'hDEAD_BEEF;
    cycle();
    chk("fetch_if_valid_c3", bus.if_valid, 1);
    chk("fetch_if_rdata", bus.if_rdata, 32'hDEAD_BEEF);
    bus.mem_rvalid = 0; bus.if_req = 0;
    cycle();
    chk("fetch_if_valid_pulse", bus.if_valid, 0);

    // Store with two ready stalls and a slow response
    bus.d_req = 1; bus.d_we = 1; bus.d_addr = 32'h20; bus.d_wdata = 32'h1234_5678;
    bus.d_wstrb = 4'b0011;
    dv_cnt = 0; dv_at = -1; iv_cnt = 0; mr_cnt = 0;
    for (int c = 0; c <= 10; c++) begin
      if (bus.d_valid) begin dv_cnt++; dv_at = c; end
      if (bus.if_valid) iv_cnt++;
      if (bus.mem_req) mr_cnt++;
      if (c >= 1 && c <= 3) begin
        chk("store_addr", bus.mem_addr, 32'h20);
        chk("store_wdata", bus.mem_wdata, 32'h1234_5678);
        chk("store_wstrb", bus.mem_wstrb, 4'b0011);
        chk("store_we", bus.mem_we, 1);
      end
      bus.mem_ready  = (c == 3);
      bus.mem_rvalid = (c == 7);
      bus.mem_rdata  = 32'h0000_0777;
      if (c == 8) bus.d_req = 0;
      cycle();
    end
    chk("store_mem_req_cycles", mr_cnt, 3);
    chk("store_d_valid_count", dv_cnt, 1);
    chk("store_d_valid_cycle", dv_at, 8);
    chk("store_if_valid_count", iv_cnt, 0);

    // Simultaneous load and fetch: data first, fetch right after
    bus.if_req = 1; bus.if_addr = 32'h80; bus.d_req = 1; bus.d_we = 0; bus.d_addr = 32'h40;
    for (int c = 0; c <= 8; c++) begin
      case (c)
        1: begin
          chk("sim_first_req", bus.mem_req, 1);
          chk("sim_first_addr", bus.mem_addr, 32'h40);
        end
        3: begin
          chk("sim_d_valid", bus.d_valid, 1);
          chk("sim_no_if_valid", bus.if_valid, 0);
          bus.d_req = 0;
        end
        5: begin
          chk("sim_fetch_req", bus.mem_req, 1);
          chk("sim_fetch_addr", bus.mem_addr, 32'h80);
        end
        7: begin
          chk("sim_if_valid", bus.if_valid, 1);
          bus.if_req = 0;
        end
        default: ;
      endcase
      bus.mem_ready  = (c == 1) || (c == 5);
      bus.mem_rvalid = (c == 2) || (c == 6);
      bus.mem_rdata  = 32'h1111_0000 + 32'(c);
      cycle();
    end

    // Both sides held: grant order shows the starvation guard (or its absence)
    bus.if_req = 1; bus.if_addr = 32'h100; bus.d_req = 1; bus.d_we = 0; bus.d_addr = 32'h200;
    bus.mem_ready = 1; bus.mem_rvalid = 1;
    for (int i = 0; i < 6; i++) gr[i] = -1;
    ngr = 0; prev = 0; done = 0;
    for (int c = 0; c < 60 && !done; c++) begin
      if (bus.mem_req && !prev && ngr < 6) begin
        gr[ngr] = (bus.mem_addr == 32'h200) ? 1 : 0;
        ngr++;
      end
      prev = bus.mem_req;
      if (ngr >= 6 && (bus.if_valid || bus.d_valid)) begin
        done = 1;
        bus.if_req = 0; bus.d_req = 0; bus.mem_ready = 0; bus.mem_rvalid = 0;
      end
      cycle();
    end
    chk("starve_grants_seen", ngr, 6);
    for (int i = 0; i < 6; i++) begin
      chk($sformatf("starve_grant%0d_is_data", i), gr[i],
          (Guard && ((i % (MaxRun + 1)) == MaxRun)) ? 0 : 1);
    end
    cycle();

    // Reset in the middle of a wait; the orphaned response must be ignored
    bus.d_req = 1; bus.d_we = 0; bus.d_addr = 32'h300;
    cycle();
    bus.mem_ready = 1;
    cycle();
    bus.mem_ready = 0;
    chk("rst_in_wait_req_low", bus.mem_req, 0);
    rst_n = 0;
    model_reset();
    #1;
    check_all_zero("rst_mid_wait");
    bus.d_req = 0;
    cycle();
    rst_n = 1;
    bus.mem_rvalid = 1; bus.mem_rdata = 32'h5555_AAAA;
    cycle();
    bus.mem_rvalid = 0;
    chk("late_rsp_no_d_valid", bus.d_valid, 0);
    chk("late_rsp_d_rdata", bus.d_rdata, 0);
    cycle();
    chk("late_rsp_still_no_valid", bus.d_valid, 0);
    bus.d_req = 1; bus.d_we = 0; bus.d_addr = 32'h400;
    drain(32'hCAFE_0001);
    chk("after_rst_d_rdata", bus.d_rdata, 32'hCAFE_0001);

    // Stray response in idle
    bus.mem_rvalid = 1; bus.mem_rdata = 32'hFFFF_FFFF;
    repeat (2) cycle();
    chk("stray_if_rdata", bus.if_rdata, 0);
    chk("stray_d_rdata", bus.d_rdata, 32'hCAFE_0001);
    chk("stray_if_valid", bus.if_valid, 0);
    chk("stray_d_valid", bus.d_valid, 0);
    bus.mem_rvalid = 0; bus.if_req = 1; bus.if_addr = 32'h504;
    cycle();
    chk("stray_then_grant", bus.mem_req, 1);
    drain(32'h0BAD_F00D);
    chk("stray_then_if_rdata", bus.if_rdata, 32'h0BAD_F00D);

    // Random traffic with stalls and stray responses
    for (int c = 0; c < 4000; c++) begin
      if (!bus.if_req || bus.if_valid) begin
        bus.if_req  = 1'($urandom_range(0, 1));
        bus.if_addr = $urandom;
      end
      if (!bus.d_req || bus.d_valid) begin
        bus.d_req   = 1'($urandom_range(0, 1));
        bus.d_we    = 1'($urandom_range(0, 1));
        bus.d_addr  = $urandom;
        bus.d_wdata = $urandom;
        bus.d_wstrb = 4'($urandom);
      end
      bus.mem_ready  = ($urandom_range(0, 3) != 0);
      bus.mem_rvalid = m_wait ? 1'($urandom_range(0, 1)) : ($urandom_range(0, 7) == 0);
      bus.mem_rdata  = $urandom;
      cycle();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
